md: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline, sitting beside the ALU in the EX stage. It performs signed/unsigned 32×32 multiply and 32/32 divide as multi-cycle operations into the HI/LO register pair, and accepts direct HI/LO writes (`mthi`/`mtlo`). `busy` and `start` are used by the hazard unit to stall subsequent HI/LO-dependent instructions.

---
 rtl/md_if.sv | 35 +++
 rtl/md.sv | 137 +++++++++++++
 tb/tb_md.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// md_if: operand, control and result signals of the multiply/divide unit.
//
// Signals
//   A, B     operands (multiplicand/dividend, multiplier/divisor)
//   WD       write data for mthi/mtlo
//   mthi     write WD into HI at the clock edge
//   mtlo     write WD into LO at the clock edge
//   start    one-cycle request to begin the operation selected by MDOp
//   MDOp     00 mult, 01 multu, 10 div, 11 divu
//   busy     operation in flight
//   hi, lo   HI/LO registers
//
// Modports: master drives operands/controls (pipeline side), slave is md.
interface md_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] WD;
    logic        mthi;
    logic        mtlo;
    logic        start;
    logic [1:0]  MDOp;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output A, B, WD, mthi, mtlo, start, MDOp,
        input  busy, hi, lo
    );

    modport slave (
        input  A, B, WD, mthi, mtlo, start, MDOp,
        output busy, hi, lo
    );
endinterface

// File: rtl/md.sv
// md: multi-cycle multiply/divide unit with HI/LO register pair for the
// EX stage of a five-stage MIPS pipeline.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   bus        md_if.slave: A, B, WD, mthi, mtlo, start, MDOp in;
//              busy, hi, lo out
//   dbg_state  current FSM state (0 IDLE, 1 RUN)
//
// Configuration macro: MD_DIVZERO_KEEP_EN
//   defined   -> div/divu by zero leaves HI/LO unchanged
//   undefined -> div/divu by zero writes HI=A, LO=0xFFFFFFFF
//
// Handshake: start is a one-cycle request sampled only while busy=0.
// An accepted start raises busy after that edge; busy stays high for
// 5 (mult/multu) or 10 (div/divu) cycles and falls on the edge that
// writes the result. start, mthi and mtlo seen while busy=1 are
// ignored. busy is purely registered; the hazard unit ORs in start.
module md (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus,
    output logic dbg_state
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Result datapath, driven only from latched operands.
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic        div_zero;

    always_comb begin
        // Sign-extend for mult, zero-extend for multu; the low 64 bits of
        // the product are then correct for both interpretations.
        a_ext = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        b_ext = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
        prod  = a_ext * b_ext;

        // Signed divide through magnitudes. 0x80000000 has magnitude
        // 0x80000000 as an unsigned value, so the overflow case
        // 0x80000000 / -1 naturally yields LO=0x80000000, HI=0.
        a_neg    = ~op_q[0] & a_q[31];
        b_neg    = ~op_q[0] & b_q[31];
        a_mag    = a_neg ? (32'd0 - a_q) : a_q;
        b_mag    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
        quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mthi) hi_d = bus.WD;
                if (bus.mtlo) lo_d = bus.WD;
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.MDOp;
                    cnt_d   = bus.MDOp[1] ? 4'd10 : 4'd5;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Counter reaches zero on this edge: commit the result.
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
`ifdef MD_DIVZERO_KEEP_EN
                        hi_d = hi_q;
                        lo_d = lo_q;
`else
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy  = (state_q == S_RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_md.sv
// tb_md: randomized self-checking bench for md against an arithmetic
// reference model of HI/LO.
module tb_md;
    logic clk;
    logic reset;
    logic dbg_state;

    md_if bus ();

    md dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [31:0] mdl_hi, mdl_lo;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: {HI,LO} after an operation, from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op,
                                          input logic [31:0] hi0, input logic [31:0] lo0);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[1] && b == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
            return {hi0, lo0};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end
        case (op)
            2'd0:    return 64'(sa * sb);
            2'd1:    return ua * ub;
            2'd2: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input bit poke, input bit with_mt);
        int cycles;
        int exp_len;
        logic [63:0] res;
        bus.A = a; bus.B = b; bus.MDOp = op; bus.start = 1'b1;
        if (with_mt) begin
            bus.WD   = $urandom;
            bus.mthi = 1'b1;
            mdl_hi   = bus.WD;
        end
        exp_q.push_back(model(a, b, op, mdl_hi, mdl_lo));
        exp_len = op[1] ? 10 : 5;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0;
        // Operands wander during RUN; the unit must use its latched copy.
        bus.A = $urandom; bus.B = $urandom; bus.MDOp = 2'($urandom);
        if (with_mt) check("mt_with_start", {32'b0, bus.hi}, {32'b0, mdl_hi});
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 20) begin
            cycles++;
            if (poke && cycles == 1) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.WD = $urandom;
            end
            @(negedge clk);
            if (poke && cycles == 1) begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
                check("mt_while_busy", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
            end
        end
        check("busy_len", 64'(cycles), 64'(exp_len));
        res = exp_q.pop_front();
        check("result", {bus.hi, bus.lo}, res);
        mdl_hi = res[63:32];
        mdl_lo = res[31:0];
    endtask

    task automatic write_mt(input bit to_hi, input logic [31:0] wd);
        bus.WD = wd;
        if (to_hi) begin bus.mthi = 1'b1; mdl_hi = wd; end
        else       begin bus.mtlo = 1'b1; mdl_lo = wd; end
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check(to_hi ? "mthi" : "mtlo", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        reset = 1'b0;
        bus.A = '0; bus.B = '0; bus.WD = '0; bus.MDOp = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.start = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        #2;
        check("reset_hilo_async", {bus.hi, bus.lo}, 64'd0);
        repeat (3) @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(32'd100000, 32'd928172, 2'd0, 0, 0);
        check("mult_const", {bus.hi, bus.lo}, 64'h00000015_9C561380);
        run_op(32'hFFFF_FFFF, 32'd2, 2'd0, 0, 0);
        check("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
        run_op(32'hFFFF_FFFF, 32'd2, 2'd1, 0, 0);
        check("multu_const", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
        run_op(32'hFFFF_FFF9, 32'd2, 2'd2, 0, 0);
        check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(32'd7, 32'd2, 2'd3, 0, 0);
        check("divu_const", {bus.hi, bus.lo}, 64'h00000001_00000003);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 0, 0);
        check("div_ovf_const", {bus.hi, bus.lo}, 64'h00000000_80000000);

        write_mt(1'b1, 32'h1234_5678);
        write_mt(1'b0, 32'hCAFE_BABE);
        check("mt_const", {bus.hi, bus.lo}, 64'h12345678_CAFEBABE);

        run_op(32'd5, 32'd0, 2'd3, 0, 0);
`ifdef MD_DIVZERO_KEEP_EN
        check("divzero_const", {bus.hi, bus.lo}, 64'h12345678_CAFEBABE);
`else
        check("divzero_const", {bus.hi, bus.lo}, 64'h00000005_FFFFFFFF);
`endif

        run_op(32'd1000, 32'd7, 2'd2, 1, 0);
        run_op(32'h0000_4321, 32'hFFFF_0001, 2'd0, 1, 0);
        run_op(32'd77, 32'd3, 2'd3, 0, 1);

        // Back-to-back randomized operations, occasionally divide by zero.
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a divide aborts it.
        bus.A = 32'd100; bus.B = 32'd3; bus.MDOp = 2'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        mdl_hi = '0; mdl_lo = '0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        check("abort_hold", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        run_op(32'hDEAD_BEEF, 32'd16, 2'd3, 0, 0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
